// File: rtl/shared_pkg.sv
// ============================================================================
// Module  : shared_pkg
// Brief   : Opcode encoding and default geometry for the SPI-attached RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

package shared_pkg;

  localparam int MEM_DEPTH_DEF = 256;
  localparam int ADDR_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } opcode_e;

endpackage

`default_nettype wire

// File: rtl/spi_ram_mem.sv
// ============================================================================
// Module  : spi_ram_mem
// Brief   : Byte-wide storage, one write port and one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [MEM_DEPTH];
  logic [7:0] rdata_d;
  logic [7:0] rdata_q;

  // Read register only moves on a read so the last returned byte is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/spi_ram.sv
// ============================================================================
// Module  : spi_ram
// Brief   : Command decoder, address pointers and read handshake for SPI RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_ram
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  opcode_e              opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_SIZE-1:0] rd_ptr_d, rd_ptr_q;
  logic                 tx_valid_d, tx_valid_q;
  logic                 rd_seen_d, rd_seen_q;
  logic                 mem_we;
  logic                 mem_re;
  logic [7:0]           mem_rdata;

  assign opcode  = opcode_e'(rx_data[9:8]);
  assign payload = rx_data[7:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (rx_valid) begin
      case (opcode)
        WR_ADDR: wr_ptr_d = payload[ADDR_SIZE-1:0];
        WR_DATA: begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        RD_ADDR: rd_ptr_d = payload[ADDR_SIZE-1:0];
        RD_DATA: begin
          mem_re     = 1'b1;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          tx_valid_d = 1'b1;
          rd_seen_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_valid_q <= tx_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (payload),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Storage has no reset, so tx_data reads as zero until the first read after reset.
  assign tx_data  = rd_seen_q ? mem_rdata : 8'h00;
  assign tx_valid = tx_valid_q;

endmodule

`default_nettype wire
